// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and load/store.
// One access in flight at a time; data has priority but yields to fetch after a bounded streak.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [3:0]        streak_reg;
    logic              owner_d_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg;
    logic              if_valid_reg, d_valid_reg;
    logic              accept, pick_d, done;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        pick_d     = 1'b0;
        done       = 1'b0;
        mem_en     = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = if_req | d_req;
                // Data wins ties until it has used up its streak allowance.
                pick_d = d_req & (~if_req | (streak_reg < STREAK_MAX));
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                mem_en     = 1'b1;
                if_gnt     = ~owner_d_reg;
                d_gnt      = owner_d_reg;
                state_next = WAIT;
            end
            WAIT: begin
                done = (cnt_reg == 4'd0);
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            streak_reg   <= '0;
            owner_d_reg  <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            if_valid_reg <= done & ~owner_d_reg;
            d_valid_reg  <= done & owner_d_reg;
            if (accept) begin
                owner_d_reg <= pick_d;
                addr_reg    <= pick_d ? d_addr : if_addr;
                we_reg      <= pick_d & d_we;
                if (pick_d) wdata_reg <= d_wdata;
                if (pick_d && if_req)
                    streak_reg <= (streak_reg == STREAK_MAX) ? STREAK_MAX : streak_reg + 4'd1;
                else
                    streak_reg <= '0;
            end
            if (state_reg == ISSUE)
                cnt_reg <= LAT_LOAD;
            else if (state_reg == WAIT && !done)
                cnt_reg <= cnt_reg - 4'd1;
            // Stores complete without touching the load data register.
            if (done) begin
                if (!owner_d_reg)
                    if_rdata_reg <= mem_rdata;
                else if (!we_reg)
                    d_rdata_reg <= mem_rdata;
            end
        end
    end

    assign busy      = (state_reg != IDLE);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign if_valid  = if_valid_reg;
    assign d_valid   = d_valid_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-timing model with its own shadow memory.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit [31:0] init_val(input logic [11:0] idx);
        if (idx == 12'h100) return 32'h00A1B2C3;
        return {20'hC0DE0, idx} ^ 32'h13572468;
    endfunction

    // Memory environment: read data appears exactly LAT cycles after the mem_en cycle.
    bit [31:0] env_mem [0:4095];
    bit        env_wr  [0:4095];
    bit [31:0] dl      [0:LAT-1];
    assign mem_rdata = dl[LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr[11:0]] <= mem_wdata;
            env_wr[mem_addr[11:0]]  <= 1'b1;
        end
        dl[0] <= (mem_en && !mem_we)
                 ? (env_wr[mem_addr[11:0]] ? env_mem[mem_addr[11:0]] : init_val(mem_addr[11:0]))
                 : $urandom();
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end

    // Reference model: an accepted access in cycle A gives gnt/mem_en in A+1, busy A+1..A+LAT+1,
    // valid (and next possible acceptance) in A+LAT+2.
    int        cyc = 0;
    bit        acc_v = 1'b0;
    int        acc_cyc = 0;
    bit        own_d = 1'b0, m_we = 1'b0, prev_en = 1'b0;
    bit [31:0] m_addr = '0, m_wdata = '0, exp_data = '0, e_ifr = '0, e_dr = '0;
    int        streak = 0;
    bit [31:0] ref_mem [0:4095];
    bit        ref_wr  [0:4095];

    always @(negedge clk) begin
        bit e_busy, e_iss, e_done;
        cyc++;
        if (reset) begin
            acc_v = 1'b0; streak = 0; own_d = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; e_ifr = '0; e_dr = '0;
        end
        e_busy = !reset && acc_v && cyc >= acc_cyc + 1 && cyc <= acc_cyc + LAT + 1;
        e_iss  = !reset && acc_v && cyc == acc_cyc + 1;
        e_done = !reset && acc_v && cyc == acc_cyc + LAT + 2;
        if (e_done) begin
            if (!own_d) e_ifr = exp_data;
            else if (!m_we) e_dr = exp_data;
            acc_v = 1'b0;
        end
        chk("busy",       busy,      e_busy);
        chk("if_gnt",     if_gnt,    e_iss && !own_d);
        chk("d_gnt",      d_gnt,     e_iss && own_d);
        chk("mem_en",     mem_en,    e_iss);
        chk("mem_we",     mem_we,    m_we);
        chk("mem_addr",   mem_addr,  m_addr);
        chk("mem_wdata",  mem_wdata, m_wdata);
        chk("if_valid",   if_valid,  e_done && !own_d);
        chk("d_valid",    d_valid,   e_done && own_d);
        chk("if_rdata",   if_rdata,  e_ifr);
        chk("d_rdata",    d_rdata,   e_dr);
        chk("mem_en_b2b", prev_en && mem_en, 1'b0);
        prev_en = mem_en;
        if (!reset && !e_busy && (if_req || d_req)) begin
            own_d = d_req && (!if_req || streak < MAXS);
            if (own_d) streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            else streak = 0;
            m_addr = own_d ? d_addr : if_addr;
            m_we   = own_d && d_we;
            if (own_d) m_wdata = d_wdata;
            if (m_we) begin
                ref_mem[m_addr[11:0]] = m_wdata;
                ref_wr[m_addr[11:0]]  = 1'b1;
            end else begin
                exp_data = ref_wr[m_addr[11:0]] ? ref_mem[m_addr[11:0]] : init_val(m_addr[11:0]);
            end
            acc_v   = 1'b1;
            acc_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string     ord;
        bit [31:0] saved;
        int        last, t, ngr;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        reset = 1'b0;

        // Single fetch
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("t1_if_gnt", if_gnt, 1'b1);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        if_req = 1'b0;
        step(); chk("t1_busy_c2", busy, 1'b1);
        step(); chk("t1_busy_c3", busy, 1'b1); chk("t1_valid_c3", if_valid, 1'b0);
        step();
        chk("t1_if_valid", if_valid, 1'b1);
        chk("t1_if_rdata", if_rdata, 32'h00A1B2C3);
        chk("t1_busy_c4", busy, 1'b0);

        // Simultaneous requests: data first, then fetch
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        step();
        chk("t2_d_gnt", d_gnt, 1'b1);
        chk("t2_if_gnt_c1", if_gnt, 1'b0);
        d_req = 1'b0;
        repeat (3) step();
        chk("t2_d_valid", d_valid, 1'b1);
        chk("t2_if_gnt_c4", if_gnt, 1'b0);
        step();
        chk("t2_if_gnt_c5", if_gnt, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        if_req = 1'b0;
        repeat (3) step();

        // Store then load of the same address
        chk("t3_d_rdata_pre", d_rdata, {20'hC0DE0, 12'h200} ^ 32'h13572468);
        saved = d_rdata;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        step();
        chk("t3_mem_en", mem_en, 1'b1);
        chk("t3_mem_we", mem_we, 1'b1);
        chk("t3_mem_addr", mem_addr, 32'h10);
        chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t3_d_gnt", d_gnt, 1'b1);
        d_req = 1'b0; d_we = 1'b0;
        step(); chk("t3_mem_en_c2", mem_en, 1'b0);
        repeat (2) step();
        chk("t3_d_valid", d_valid, 1'b1);
        chk("t3_d_rdata_hold", d_rdata, saved);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        step();
        chk("t3_load_gnt", d_gnt, 1'b1);
        d_req = 1'b0;
        repeat (3) step();
        chk("t3_load_valid", d_valid, 1'b1);
        chk("t3_load_data", d_rdata, 32'hDEADBEEF);

        // Starvation guard
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        ord = "";
        for (int k = 0; k < 40 && ord.len() < 6; k++) begin
            step();
            if (if_gnt) ord = {ord, "F"};
            if (d_gnt) ord = {ord, "D"};
        end
        n_total++;
        if (ord == "DDDDFD") n_pass++;
        else $display("FAIL t4_order: actual=%s required=DDDDFD", ord);
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) step();

        // Reset during WAIT
        if_req = 1'b1; if_addr = 32'h500;
        step();
        chk("t5_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_if_rdata", if_rdata, 32'h0);
        chk("t5_d_rdata", d_rdata, 32'h0);
        repeat (2) step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("t5_no_valid", if_valid | d_valid, 1'b0);
            step();
        end
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("t5_refetch_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        repeat (3) step();
        chk("t5_refetch_valid", if_valid, 1'b1);
        chk("t5_refetch_data", if_rdata, 32'h00A1B2C3);

        // Back-to-back fetches
        if_req = 1'b1; if_addr = 32'h600;
        last = -1; t = 0; ngr = 0;
        for (int k = 0; k < 30 && ngr < 3; k++) begin
            step();
            t++;
            if (if_gnt) begin
                if (last >= 0) chk("t6_spacing", 64'(t - last), 64'(LAT + 2));
                last = t;
                ngr++;
            end
        end
        chk("t6_count", 64'(ngr), 64'd3);
        if_req = 1'b0;
        repeat (3) step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit gi, gd;
            gi = if_gnt;
            gd = d_gnt;
            step();
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rnd_rst_busy", busy, 1'b0);
                chk("rnd_rst_mem_en", mem_en, 1'b0);
                repeat ($urandom_range(1, 2)) step();
                reset = 1'b0;
                gi = 1'b0;
                gd = 1'b0;
            end
            if (if_req) begin
                if (gi) begin
                    if ($urandom_range(0, 1) == 1) if_addr = $urandom();
                    else if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom();
            end
            if (d_req) begin
                if (gd) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_addr = $urandom(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
                    end else d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port memory between the instruction-fetch port and the load/store data port.
- Arbitrates between the two, issues one memory access at a time, waits out a fixed memory latency, and returns read data with a one-cycle valid pulse to the owning port.
- Sits between the cpu core and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held high until if_gnt is seen
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted (1-cycle pulse)
if_valid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request, held high until d_gnt is seen
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data accepted (1-cycle pulse)
d_valid  out  1  load data valid, or store complete (1-cycle pulse)
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe (1 cycle)
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous): state IDLE, streak 0, and all outputs 0 (including rdata buses and mem_* outputs).
- Reset mid-operation aborts the access; no gnt or valid pulse is produced afterwards.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Select the winner and latch owner, addr, we and wdata at the clock edge.
  - Next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr, mem_wdata driven from the latched values.
  - The winner's gnt=1 in this cycle.
  - Next state is WAIT; the latency counter is loaded with MEM_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - The cycle with counter==0 is cycle T+MEM_LAT, where T is the ISSUE cycle.
  - At the end of that cycle, mem_rdata is captured into the owner's rdata register, the owner's valid is set for the next cycle, and the next state is IDLE.
- Valid and rdata:
  - valid is high in cycle T+MEM_LAT+1, concurrent with IDLE.
  - IDLE may accept a new request in that same cycle.
  - Peak throughput is one access per MEM_LAT+2 cycles.
- Stores:
  - Identical timing to loads.
  - d_valid signals completion; d_rdata is not updated and holds its previous value.
- mem_en is 0 in every state except ISSUE.
- mem_addr, mem_we and mem_wdata hold their last values outside ISSUE.
- if_req and d_req are ignored outside IDLE.
- Requester protocol: drop req in the cycle after gnt, or keep it high to request again.
- Arbitration (evaluated only in IDLE):
  - Only one request high: that requester wins.
  - Both high and streak < MAX_DATA_STREAK: data wins.
  - Both high and streak == MAX_DATA_STREAK: fetch wins.
- Streak counter:
  - On a data grant with if_req high: increment, saturating at MAX_DATA_STREAK.
  - On a data grant with if_req low: clear to 0.
  - On a fetch grant: clear to 0.
- if_gnt and d_gnt are never high together; if_valid and d_valid are never high together.
- rdata registers hold their value between valid pulses.

Test Plan:
- Single fetch, MEM_LAT=2, if_addr=0x100, memory returns 0x00A1B2C3:
  - if_req in cycle 0 -> if_gnt, mem_en and mem_addr=0x100 in cycle 1.
  - if_valid in cycle 4 with if_rdata=0x00A1B2C3.
  - busy high in cycles 1..3 only.
- Simultaneous if_req and d_req (load, 0x200) in cycle 0:
  - d_gnt in cycle 1, d_valid in cycle 4.
  - if_gnt in cycle 5 with mem_addr=0x100.
- Starvation guard: d_req and if_req held high continuously, MAX_DATA_STREAK=4:
  - Grant order is D,D,D,D,F,D,...
  - Streak returns to 0 after the fetch grant.
- Store d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF:
  - mem_en=mem_we=1 for exactly 1 cycle with those values.
  - d_valid pulses in cycle T+MEM_LAT+1; d_rdata unchanged.
  - A following load of 0x10 returns 0xDEADBEEF.
- Reset asserted while in WAIT:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No valid pulse afterwards.
  - After reset deasserts, a new fetch completes with normal timing.
- Back-to-back fetches with if_req held high:
  - Accesses issue every MEM_LAT+2 cycles.
  - if_valid and the next acceptance share a cycle.
  - mem_en is never high in two consecutive cycles.
